// File: rtl/cc_randomgen_pkg.sv
// Shared definitions for the random word generator: FSM states and LFSR constants.
// The tap mask selects bits 7,5,4,3, i.e. the polynomial x^8+x^6+x^5+x^4+1.
package cc_randomgen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        VALID = 2'd2
    } randomgen_state_t;

    localparam logic [7:0] TAP_MASK           = 8'hB8;
    localparam logic [7:0] DEFAULT_RESET_SEED = 8'hA5;

endpackage

// File: rtl/cc_lfsr8_step.sv
// One step of the 8-bit Fibonacci LFSR: shift left, feedback enters at bit 0.
// A nonzero state never maps to zero, so the sequence has period 255.
module cc_lfsr8_step
    import cc_randomgen_pkg::*;
(
    input  logic [7:0] state,
    output logic [7:0] next_state
);

    assign next_state = {state[6:0], ^(state & TAP_MASK)};

endmodule

// File: rtl/cc_random_gen.sv
// Random word generator: steps an LFSR a fixed number of times per request and
// presents the result with a valid/ack handshake to the consumer mux.
module cc_random_gen
    import cc_randomgen_pkg::*;
#(
    parameter int         RANDOMGEN_RANDOMWIDTH = 8,
    parameter int         RANDOMGEN_SELECTWIDTH = 2,
    parameter int         RANDOMGEN_SHIFTS      = 8,
    parameter logic [7:0] RANDOMGEN_RESETSEED   = DEFAULT_RESET_SEED
)
(
    input  logic                             CC_RANDOMGEN_CLOCK_50,
    input  logic                             CC_RANDOMGEN_RESET_InHigh,
    input  logic                             CC_RANDOMGEN_seedLoad_In,
    input  logic [RANDOMGEN_RANDOMWIDTH-1:0] CC_RANDOMGEN_seed_InBUS,
    input  logic                             CC_RANDOMGEN_request_In,
    input  logic                             CC_RANDOMGEN_ack_In,
    output logic [RANDOMGEN_RANDOMWIDTH-1:0] CC_RANDOMGEN_RANDOM_OutBUS,
    output logic [RANDOMGEN_SELECTWIDTH-1:0] CC_RANDOMGEN_select_OutBUS,
    output logic                             CC_RANDOMGEN_valid_Out,
    output logic                             CC_RANDOMGEN_busy_Out
);

    // Counter reload: the final step is taken when the counter reads zero.
    localparam logic [7:0] SHIFT_LOAD = 8'(RANDOMGEN_SHIFTS - 1);

    randomgen_state_t state;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_next;
    logic [7:0]       count;
    logic [7:0]       seed_raw;
    logic [7:0]       seed_value;

    cc_lfsr8_step u_step (
        .state      (lfsr),
        .next_state (lfsr_next)
    );

    // A zero seed would lock the LFSR at zero, so it is replaced by the reset seed.
    assign seed_raw   = 8'(CC_RANDOMGEN_seed_InBUS);
    assign seed_value = (seed_raw == 8'h00) ? RANDOMGEN_RESETSEED : seed_raw;

    always_ff @(posedge CC_RANDOMGEN_CLOCK_50) begin
        if (CC_RANDOMGEN_RESET_InHigh) begin
            lfsr                       <= RANDOMGEN_RESETSEED;
            state                      <= IDLE;
            count                      <= 8'd0;
            CC_RANDOMGEN_RANDOM_OutBUS <= '0;
            CC_RANDOMGEN_select_OutBUS <= '0;
            CC_RANDOMGEN_valid_Out     <= 1'b0;
            CC_RANDOMGEN_busy_Out      <= 1'b0;
        end else if (CC_RANDOMGEN_seedLoad_In) begin
            lfsr                   <= seed_value;
            state                  <= IDLE;
            count                  <= 8'd0;
            CC_RANDOMGEN_valid_Out <= 1'b0;
            CC_RANDOMGEN_busy_Out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CC_RANDOMGEN_request_In) begin
                        state                 <= SHIFT;
                        count                 <= SHIFT_LOAD;
                        CC_RANDOMGEN_busy_Out <= 1'b1;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_next;
                    if (count == 8'd0) begin
                        CC_RANDOMGEN_RANDOM_OutBUS <= RANDOMGEN_RANDOMWIDTH'(lfsr_next);
                        CC_RANDOMGEN_select_OutBUS <= lfsr_next[RANDOMGEN_SELECTWIDTH-1:0];
                        CC_RANDOMGEN_valid_Out     <= 1'b1;
                        state                      <= VALID;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                VALID: begin
                    // Ack with a fresh request chains straight into the next word.
                    if (CC_RANDOMGEN_ack_In) begin
                        CC_RANDOMGEN_valid_Out <= 1'b0;
                        if (CC_RANDOMGEN_request_In) begin
                            state <= SHIFT;
                            count <= SHIFT_LOAD;
                        end else begin
                            state                 <= IDLE;
                            CC_RANDOMGEN_busy_Out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state                  <= IDLE;
                    count                  <= 8'd0;
                    CC_RANDOMGEN_valid_Out <= 1'b0;
                    CC_RANDOMGEN_busy_Out  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_random_gen.sv
// Self-checking bench for cc_random_gen: LFSR step vectors, handshake sequences,
// seed/reset corner cases and a full-period free run with one step per word.
module tb_cc_random_gen;
    import cc_randomgen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     = 1'b1;
    logic       seed_load = 1'b0;
    logic [7:0] seed      = 8'h00;
    logic       request   = 1'b0;
    logic       ack       = 1'b0;
    logic [7:0] random_word;
    logic [1:0] select_word;
    logic       valid;
    logic       busy;

    logic       fr_reset   = 1'b1;
    logic       fr_request = 1'b0;
    logic       fr_ack     = 1'b0;
    logic [7:0] fr_random;
    logic [1:0] fr_select;
    logic       fr_valid;
    logic       fr_busy;

    logic [7:0] step_in = 8'h00;
    logic [7:0] step_out;

    int tests_run    = 0;
    int tests_failed = 0;

    cc_random_gen dut (
        .CC_RANDOMGEN_CLOCK_50      (clk),
        .CC_RANDOMGEN_RESET_InHigh  (reset),
        .CC_RANDOMGEN_seedLoad_In   (seed_load),
        .CC_RANDOMGEN_seed_InBUS    (seed),
        .CC_RANDOMGEN_request_In    (request),
        .CC_RANDOMGEN_ack_In        (ack),
        .CC_RANDOMGEN_RANDOM_OutBUS (random_word),
        .CC_RANDOMGEN_select_OutBUS (select_word),
        .CC_RANDOMGEN_valid_Out     (valid),
        .CC_RANDOMGEN_busy_Out      (busy)
    );

    cc_random_gen #(.RANDOMGEN_SHIFTS(1)) dut_free (
        .CC_RANDOMGEN_CLOCK_50      (clk),
        .CC_RANDOMGEN_RESET_InHigh  (fr_reset),
        .CC_RANDOMGEN_seedLoad_In   (1'b0),
        .CC_RANDOMGEN_seed_InBUS    (8'h00),
        .CC_RANDOMGEN_request_In    (fr_request),
        .CC_RANDOMGEN_ack_In        (fr_ack),
        .CC_RANDOMGEN_RANDOM_OutBUS (fr_random),
        .CC_RANDOMGEN_select_OutBUS (fr_select),
        .CC_RANDOMGEN_valid_Out     (fr_valid),
        .CC_RANDOMGEN_busy_Out      (fr_busy)
    );

    cc_lfsr8_step u_step (
        .state      (step_in),
        .next_state (step_out)
    );

    typedef struct {
        logic [7:0] in_value;
        logic [7:0] out_value;
    } step_vector_t;

    step_vector_t step_table [19];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input logic [7:0] exp_random, input logic [1:0] exp_select,
                            input logic exp_valid, input logic exp_busy);
        checkOutput({name, ".random"}, 32'(random_word), 32'(exp_random));
        checkOutput({name, ".select"}, 32'(select_word), 32'(exp_select));
        checkOutput({name, ".valid"},  32'(valid),       32'(exp_valid));
        checkOutput({name, ".busy"},   32'(busy),        32'(exp_busy));
    endtask

    // Drive one set of inputs, let one rising edge pass, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic sl, input logic [7:0] sd,
                                 input logic rq, input logic ak);
        reset     = r;
        seed_load = sl;
        seed      = sd;
        request   = rq;
        ack       = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input string name, input int n, input logic exp_busy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput({name, ".valid"}, 32'(valid), 32'd0);
            checkOutput({name, ".busy"},  32'(busy),  32'(exp_busy));
        end
    endtask

    // Request from IDLE and expect the word after exactly eight shift edges.
    task automatic requestWord(input string name, input logic [7:0] exp_word, input logic [7:0] prev_word);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkAll({name, ".accept"}, prev_word, prev_word[1:0], 1'b0, 1'b1);
        idleCycles({name, ".shift"}, 7, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll(name, exp_word, exp_word[1:0], 1'b1, 1'b1);
    endtask

    logic seen [256];
    int   words;

    initial begin
        step_table[0]  = '{8'hA5, 8'h4A};
        step_table[1]  = '{8'h4A, 8'h95};
        step_table[2]  = '{8'h95, 8'h2A};
        step_table[3]  = '{8'h2A, 8'h54};
        step_table[4]  = '{8'h54, 8'hA9};
        step_table[5]  = '{8'hA9, 8'h53};
        step_table[6]  = '{8'h53, 8'hA7};
        step_table[7]  = '{8'hA7, 8'h4E};
        step_table[8]  = '{8'h4E, 8'h9D};
        step_table[9]  = '{8'h9D, 8'h3B};
        step_table[10] = '{8'h3B, 8'h77};
        step_table[11] = '{8'h77, 8'hEE};
        step_table[12] = '{8'hEE, 8'hDD};
        step_table[13] = '{8'hDD, 8'hBB};
        step_table[14] = '{8'hBB, 8'h76};
        step_table[15] = '{8'h76, 8'hEC};
        step_table[16] = '{8'h01, 8'h02};
        step_table[17] = '{8'h80, 8'h01};
        step_table[18] = '{8'hFF, 8'hFE};

        for (int i = 0; i < 19; i++) begin
            step_in = step_table[i].in_value;
            #1;
            checkOutput($sformatf("lfsr_step[%0d]", i), 32'(step_out), 32'(step_table[i].out_value));
        end

        // Reset wins over seedLoad, request and ack asserted alongside it.
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll("reset", 8'h00, 2'b00, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkAll("first.accept", 8'h00, 2'b00, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            else        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("first.shift.valid", 32'(valid), 32'd0);
            checkOutput("first.shift.busy",  32'(busy),  32'd1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll("first_word", 8'h4E, 2'b10, 1'b1, 1'b1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'(i % 2), 1'b0);
            checkAll("hold_valid", 8'h4E, 2'b10, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkAll("ack", 8'h4E, 2'b10, 1'b0, 1'b0);
        idleCycles("idle_after_ack", 3, 1'b0);
        requestWord("idle_hold_word", 8'hEC, 8'h4E);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Back-to-back: ack with request skips IDLE and continues the sequence.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll("reset2", 8'h00, 2'b00, 1'b0, 1'b0);
        requestWord("word_after_reset", 8'h4E, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkAll("ack_req", 8'h4E, 2'b10, 1'b0, 1'b1);
        idleCycles("ack_req.shift", 7, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll("back_to_back", 8'hEC, 2'b00, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        checkAll("seed_zero", 8'hEC, 2'b00, 1'b0, 1'b0);
        requestWord("zero_seed_word", 8'h4E, 8'hEC);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idleCycles("pre_seed.shift", 3, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h4A, 1'b1, 1'b1);
        checkAll("seed_mid_shift", 8'h4E, 2'b10, 1'b0, 1'b0);
        idleCycles("after_seed", 10, 1'b0);
        requestWord("reseeded_word", 8'h9D, 8'h4E);
        applyStimulus(1'b0, 1'b1, 8'h95, 1'b1, 1'b1);
        checkAll("seed_in_valid", 8'h9D, 2'b01, 1'b0, 1'b0);
        requestWord("seed95_word", 8'h3B, 8'h9D);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idleCycles("pre_reset.shift", 3, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkAll("reset_mid_shift", 8'h00, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAll("after_reset", 8'h00, 2'b00, 1'b0, 1'b0);
        requestWord("post_reset_word", 8'h4E, 8'h00);

        // Free run with one step per word: a full period must visit every nonzero value once.
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        words = 0;
        @(posedge clk); #1;
        fr_reset = 1'b0;
        fr_request = 1'b1;
        fr_ack = 1'b1;
        for (int c = 0; c < 2000 && words < 255; c++) begin
            @(posedge clk); #1;
            if (fr_valid) begin
                if (words == 0) checkOutput("freerun_first", 32'(fr_random), 32'h4A);
                checkOutput("freerun_nonzero", 32'(fr_random != 8'h00), 32'd1);
                checkOutput("freerun_unique", 32'(seen[fr_random]), 32'd0);
                seen[fr_random] = 1'b1;
                words++;
            end
        end
        checkOutput("freerun_count", 32'(words), 32'd255);
        fr_request = 1'b0;
        fr_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
